regfile_access_seq: RTL and testbench

Multi-cycle sequencer that sits directly upstream of the 32x32 register file (REGISTER_FILE_32x32). It accepts one 32-bit instruction word at a time and decodes rs/rt/rd and the immediate. It drives the register file read cycle and captures both operands for the ALU. It then waits for the ALU result and drives the register file write-back cycle, so READ and WRITE are never asserted together.

---
 rtl/regfile_access_seq.sv | 196 +++++++++++++++++++
 tb/tb_regfile_access_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_seq.sv
// Purpose: multi-cycle sequencer that decodes one instruction, reads two operands from the
//   register file, hands them to the ALU and writes the ALU result back.
// Latency: operands valid 3 cycles after accept; ready again 5 cycles after accept with
//   write-back, 4 without; EXEC gives up after TIMEOUT cycles.
// Backpressure: INSTR_READY is high only in IDLE; INSTR/INSTR_VALID are ignored otherwise.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   INSTR/INSTR_VALID   instruction word in, accepted while INSTR_READY
//   ADDR_R1/R2, READ    register file read port (READ high for the single RD cycle)
//   DATA_R1/R2          register file read data, sampled at the end of CAP
//   ADDR_W, DATA_W, WRITE  register file write port (WRITE high for the single WB cycle)
//   OP_A, OP_B, IMM_EXT operands and sign-extended immediate for the ALU
//   OPS_VALID           one-cycle pulse in the first EXEC cycle
//   ALU_RESULT/ALU_DONE ALU completion, only looked at in EXEC
//   ERR                 one-cycle pulse after an ALU timeout

module regfile_access_seq #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [4:0]  ADDR_R1,
  output logic [4:0]  ADDR_R2,
  output logic [4:0]  ADDR_W,
  output logic        READ,
  output logic        WRITE,
  output logic [31:0] DATA_W,
  input  logic [31:0] DATA_R1,
  input  logic [31:0] DATA_R2,
  output logic [31:0] OP_A,
  output logic [31:0] OP_B,
  output logic [31:0] IMM_EXT,
  output logic        OPS_VALID,
  input  logic [31:0] ALU_RESULT,
  input  logic        ALU_DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_EXEC,
    S_WB
  } state_t;

  // Counter value of the last EXEC cycle in which ALU_DONE is still honoured.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  exec_cnt;

  // Decoded properties of the accepted instruction, kept for the rest of the sequence.
  logic        wb_need_q;
  logic        use_r2_q;
  logic [4:0]  dest_q;

  // Decode of the incoming word (only used on the accept edge).
  logic [5:0]  in_opcode;
  logic        in_no_wb;
  logic        in_use_r2;
  logic [4:0]  in_dest;

  logic        accept;
  logic        capture;
  logic        wb_latch;
  logic        timeout_hit;

  assign in_opcode = INSTR[31:26];
  // Stores and branches never write the register file.
  assign in_no_wb  = (in_opcode == 6'h2b) || (in_opcode == 6'h04) || (in_opcode == 6'h05);
  // R-type plus the no-write-back group take their second operand from rt.
  assign in_use_r2 = (in_opcode == 6'h00) || in_no_wb;
  assign in_dest   = (in_opcode == 6'h00) ? INSTR[15:11] : INSTR[20:16];

  // Strobes come straight from the state so that an asynchronous reset drops them at once
  // and READ/WRITE can never overlap.
  assign INSTR_READY = (state == S_IDLE);
  assign READ        = (state == S_RD);
  assign WRITE       = (state == S_WB);

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    capture     = 1'b0;
    wb_latch    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (INSTR_VALID) begin
          accept    = 1'b1;
          state_nxt = S_RD;
        end
      end
      S_RD: begin
        state_nxt = S_CAP;
      end
      S_CAP: begin
        capture   = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        // A completion in the final counted cycle wins over the timeout.
        if (ALU_DONE) begin
          if (wb_need_q) begin
            wb_latch  = 1'b1;
            state_nxt = S_WB;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (exec_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_WB: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exec_cnt <= 8'd0;
    end else if (capture) begin
      exec_cnt <= 8'd0;
    end else if (state == S_EXEC) begin
      exec_cnt <= exec_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_need_q <= 1'b0;
      use_r2_q  <= 1'b0;
      dest_q    <= 5'd0;
      ADDR_R1   <= 5'd0;
      ADDR_R2   <= 5'd0;
      IMM_EXT   <= 32'd0;
    end else if (accept) begin
      wb_need_q <= !in_no_wb && (in_dest != 5'd0);
      use_r2_q  <= in_use_r2;
      dest_q    <= in_dest;
      ADDR_R1   <= INSTR[25:21];
      ADDR_R2   <= INSTR[20:16];
      IMM_EXT   <= {{16{INSTR[15]}}, INSTR[15:0]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OP_A <= 32'd0;
      OP_B <= 32'd0;
    end else if (capture) begin
      OP_A <= DATA_R1;
      OP_B <= use_r2_q ? DATA_R2 : IMM_EXT;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ADDR_W <= 5'd0;
      DATA_W <= 32'd0;
    end else if (wb_latch) begin
      ADDR_W <= dest_q;
      DATA_W <= ALU_RESULT;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OPS_VALID <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      OPS_VALID <= capture;
      ERR       <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_regfile_access_seq.sv
// Bench for regfile_access_seq: a stub register file array feeds the read ports, and each
// instruction's expected cycle-by-cycle behaviour is derived from its fields, the stub
// contents and the chosen ALU delay.
module tb_regfile_access_seq;

  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [4:0]  ADDR_R1, ADDR_R2, ADDR_W;
  logic        READ, WRITE;
  logic [31:0] DATA_W, DATA_R1, DATA_R2;
  logic [31:0] OP_A, OP_B, IMM_EXT;
  logic        OPS_VALID;
  logic [31:0] ALU_RESULT;
  logic        ALU_DONE;
  logic        ERR;

  logic [31:0] regs [32];
  int          total = 0;
  int          bad   = 0;
  logic [4:0]  exp_addr_w = 5'd0;
  logic [31:0] exp_data_w = 32'd0;

  regfile_access_seq #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W),
    .READ(READ), .WRITE(WRITE), .DATA_W(DATA_W), .DATA_R1(DATA_R1), .DATA_R2(DATA_R2),
    .OP_A(OP_A), .OP_B(OP_B), .IMM_EXT(IMM_EXT), .OPS_VALID(OPS_VALID),
    .ALU_RESULT(ALU_RESULT), .ALU_DONE(ALU_DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  assign DATA_R1 = regs[ADDR_R1];
  assign DATA_R2 = regs[ADDR_R2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(INSTR_READY), 1);
    chk({tag, "_read"}, 32'(READ), 0);
    chk({tag, "_write"}, 32'(WRITE), 0);
    chk({tag, "_opsv"}, 32'(OPS_VALID), 0);
    chk({tag, "_err"}, 32'(ERR), 0);
    chk({tag, "_ar1"}, 32'(ADDR_R1), 0);
    chk({tag, "_ar2"}, 32'(ADDR_R2), 0);
    chk({tag, "_aw"}, 32'(ADDR_W), 0);
    chk({tag, "_dw"}, DATA_W, 0);
    chk({tag, "_opa"}, OP_A, 0);
    chk({tag, "_opb"}, OP_B, 0);
    chk({tag, "_imm"}, IMM_EXT, 0);
  endtask

  // Noise on inputs the sequencer must ignore outside IDLE / EXEC.
  task automatic drive_noise();
    INSTR_VALID = 1'($urandom);
    INSTR       = $urandom;
    ALU_DONE    = 1'($urandom);
    ALU_RESULT  = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      INSTR_VALID = 1'b0;
      ALU_DONE    = 1'($urandom);
      @(negedge CLK);
      chk("idle_ready", 32'(INSTR_READY), 1);
      chk("idle_write", 32'(WRITE), 0);
      chk("idle_err", 32'(ERR), 0);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the next
  // idle cycle with INSTR_VALID low.
  task automatic run_instr(input logic [31:0] ins, input int d, input logic [31:0] res,
                           input bit rst_wb);
    logic [5:0]  op;
    logic [4:0]  rs, rt, dest;
    logic [31:0] imm, exp_a, exp_b;
    bit          no_wb, use_r2, wb, tmo;
    int          last;
    op     = ins[31:26];
    rs     = ins[25:21];
    rt     = ins[20:16];
    no_wb  = (op == 6'h2b) || (op == 6'h04) || (op == 6'h05);
    use_r2 = (op == 6'h00) || no_wb;
    dest   = (op == 6'h00) ? ins[15:11] : rt;
    wb     = !no_wb && (dest != 5'd0);
    imm    = {{16{ins[15]}}, ins[15:0]};
    exp_a  = regs[rs];
    exp_b  = use_r2 ? regs[rt] : imm;
    tmo    = (d >= TIMEOUT);
    last   = tmo ? TIMEOUT - 1 : d;

    // Cycle 0: present the instruction.
    chk("acc_ready", 32'(INSTR_READY), 1);
    INSTR       = ins;
    INSTR_VALID = 1'b1;
    ALU_DONE    = 1'($urandom);
    ALU_RESULT  = $urandom;
    // Cycle 1: RD.
    @(negedge CLK);
    chk("rd_read", 32'(READ), 1);
    chk("rd_write", 32'(WRITE), 0);
    chk("rd_ar1", 32'(ADDR_R1), 32'(rs));
    chk("rd_ar2", 32'(ADDR_R2), 32'(rt));
    chk("rd_ready", 32'(INSTR_READY), 0);
    chk("rd_err", 32'(ERR), 0);
    chk("rd_imm", IMM_EXT, imm);
    drive_noise();
    // Cycle 2: CAP.
    @(negedge CLK);
    chk("cap_read", 32'(READ), 0);
    chk("cap_opsv", 32'(OPS_VALID), 0);
    chk("cap_ready", 32'(INSTR_READY), 0);
    drive_noise();
    // Cycles 3..: EXEC.
    for (int k = 0; k <= last; k++) begin
      @(negedge CLK);
      chk("ex_opsv", 32'(OPS_VALID), (k == 0) ? 1 : 0);
      chk("ex_opa", OP_A, exp_a);
      chk("ex_opb", OP_B, exp_b);
      chk("ex_rw", {30'd0, READ, WRITE}, 0);
      chk("ex_err", 32'(ERR), 0);
      chk("ex_ready", 32'(INSTR_READY), 0);
      chk("ex_aw_hold", 32'(ADDR_W), 32'(exp_addr_w));
      chk("ex_dw_hold", DATA_W, exp_data_w);
      INSTR_VALID = 1'($urandom);
      INSTR       = $urandom;
      ALU_DONE    = (k == d);
      ALU_RESULT  = (k == d) ? res : $urandom;
    end
    @(negedge CLK);
    if (tmo) begin
      chk("tmo_err", 32'(ERR), 1);
      chk("tmo_ready", 32'(INSTR_READY), 1);
      chk("tmo_write", 32'(WRITE), 0);
    end else if (wb) begin
      exp_addr_w = dest;
      exp_data_w = res;
      chk("wb_write", 32'(WRITE), 1);
      chk("wb_read", 32'(READ), 0);
      chk("wb_aw", 32'(ADDR_W), 32'(dest));
      chk("wb_dw", DATA_W, res);
      chk("wb_ready", 32'(INSTR_READY), 0);
      chk("wb_err", 32'(ERR), 0);
      drive_noise();
      if (rst_wb) begin
        #1 RST = 1'b1;
        #1 chk("rstwb_write", 32'(WRITE), 0);
        chk_reset("rstwb");
        INSTR_VALID = 1'b0;
        ALU_DONE    = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        exp_addr_w = 5'd0;
        exp_data_w = 32'd0;
        #1 chk_reset("rstrel");
        return;
      end
      @(negedge CLK);
      chk("post_wb_ready", 32'(INSTR_READY), 1);
      chk("post_wb_write", 32'(WRITE), 0);
    end else begin
      chk("nowb_ready", 32'(INSTR_READY), 1);
      chk("nowb_write", 32'(WRITE), 0);
      chk("nowb_err", 32'(ERR), 0);
      chk("nowb_aw_hold", 32'(ADDR_W), 32'(exp_addr_w));
      chk("nowb_dw_hold", DATA_W, exp_data_w);
    end
    INSTR_VALID = 1'b0;
    ALU_DONE    = 1'b0;
  endtask

  // Invariants checked on every cycle away from the edge.
  always @(negedge CLK) begin
    if (READ && WRITE) begin
      total++;
      bad++;
      $display("FAIL rw_overlap got=1 exp=0");
    end
    if (WRITE && (ADDR_W == 5'd0)) begin
      total++;
      bad++;
      $display("FAIL write_addr0 got=0 exp=nonzero");
    end
  end

  logic [5:0]  ops [8];
  logic [31:0] rins;
  int          rd_delay;

  initial begin
    ops = '{6'h00, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h23, 6'h0f};
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    RST         = 1'b1;
    INSTR       = 32'h00221820;
    INSTR_VALID = 1'b1;
    ALU_DONE    = 1'b0;
    ALU_RESULT  = 32'd0;
    #2 chk_reset("rst_async");
    @(negedge CLK);
    chk_reset("rst_held");
    RST         = 1'b0;
    INSTR_VALID = 1'b0;
    idle_cycles(1);

    // add $3,$1,$2
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    run_instr(32'h00221820, 0, 32'd12, 1'b0);
    // addi $5,$1,-4
    regs[1] = 32'd10;
    run_instr(32'h2025FFFC, 0, 32'd6, 1'b0);
    // sw: no write-back, OP_B from rt
    run_instr(32'hAC220004, 1, 32'h1234, 1'b0);
    // rd = 0: no write-back
    run_instr(32'h00220020, 0, 32'h55, 1'b0);
    // ALU never answers
    run_instr(32'h00221820, TIMEOUT + 5, 32'd0, 1'b0);
    idle_cycles(2);
    // done in the last counted cycle wins over the timeout
    run_instr(32'h2025FFFC, TIMEOUT - 1, 32'hCAFE0001, 1'b0);
    // reset during write-back
    run_instr(32'h00221820, 2, 32'hDEAD0001, 1'b1);
    idle_cycles(1);

    repeat (40) begin
      rins        = $urandom;
      rins[31:26] = ops[$urandom_range(0, 7)];
      rd_delay    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 3))
                                                : int'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 31)] = $urandom;
      run_instr(rins, rd_delay, $urandom, 1'b0);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
